// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer read path.
package fb_pkg;

  // Read controller FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } fb_rd_state_t;

  // Skid buffer depth. It covers one buffered word plus one word in flight
  // from the memory's single-cycle read latency.
  localparam int FB_SKID_DEPTH = 2;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO between the data_mem return path and the pixel stream.
// Each entry is {last, data}; the head entry drives the pixel outputs.
// The pointers are single toggling bits, which suits the fixed depth of 2.
module rd_skid_buf
  import fb_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int SCW   = $clog2(FB_SKID_DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic [SCW-1:0]   o_count
);

  logic [WIDTH-1:0] r_mem [FB_SKID_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [SCW-1:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == SCW'(FB_SKID_DEPTH));
  // A pop frees a slot in the same cycle, so push is legal when full and popping.
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Storage, pointers and occupancy; reset empties the buffer and zeroes the data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FB_SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + SCW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - SCW'(1);
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/frame_reader.sv
// Read-side controller for data_mem: sweeps FRAME_PIXELS addresses from a
// latched base and streams the returned words over a valid/ready interface.
//
// Pixel handshake: a word transfers on a rising edge where pix_valid and
// pix_ready are both high; pix_valid never depends on pix_ready, and while
// pix_valid is high without pix_ready, pix_data and pix_last hold stable.
module frame_reader
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 3,
  parameter int FRAME_PIXELS = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last,
  output logic [1:0]            dbg_state
);

  localparam int CW  = $clog2(FRAME_PIXELS + 1);
  localparam int SCW = $clog2(FB_SKID_DEPTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIXELS - 1);

  fb_rd_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_issue_cnt;
  logic [CW-1:0]         r_acc_cnt;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_done;

  logic [DATA_WIDTH:0]   w_head;
  logic                  w_valid;
  logic [SCW-1:0]        w_count;
  logic                  w_pop;
  logic [2:0]            w_outstanding;
  logic                  w_credit;
  logic                  w_rd_en;
  logic                  w_issue_last;
  logic                  w_acc_last;

  assign w_pop         = w_valid && pix_ready;
  // Words already buffered plus the word arriving next edge; a pop this
  // cycle returns one credit so full-rate streaming never stalls.
  assign w_outstanding = 3'(w_count) + 3'(r_inflight);
  assign w_credit      = (w_outstanding < (3'(FB_SKID_DEPTH) + 3'(w_pop)));
  assign w_rd_en       = (r_state == READ) && w_credit;
  assign w_issue_last  = (r_issue_cnt == LAST_IDX);
  assign w_acc_last    = (r_acc_cnt == LAST_IDX);

  // FSM, issue/accept counters, base latch and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_acc_cnt   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) begin
        r_acc_cnt <= r_acc_cnt + CW'(1);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base      <= base_addr;
            r_issue_cnt <= '0;
            r_acc_cnt   <= '0;
            r_state     <= READ;
          end
        end
        READ: begin
          if (w_rd_en) begin
            r_issue_cnt <= r_issue_cnt + CW'(1);
            if (w_issue_last) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && w_acc_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Track the read issued last cycle so its data is pushed when it returns,
  // tagged with whether it is the final word of the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en && w_issue_last;
    end
  end

  rd_skid_buf #(
    .WIDTH (DATA_WIDTH + 1),
    .SCW   (SCW)
  ) u_skid (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_push      (r_inflight),
    .i_push_data ({r_inflight_last, rd_data}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (w_valid),
    .o_count     (w_count)
  );

  // Address wraps naturally in ADDR_WIDTH bits.
  assign rd_addr   = r_base + ADDR_WIDTH'(r_issue_cnt);
  assign rd_en     = w_rd_en;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign pix_valid = w_valid;
  assign pix_data  = w_head[DATA_WIDTH-1:0];
  assign pix_last  = w_valid && w_head[DATA_WIDTH];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: directed scenarios plus randomized frames, with a
// queue-based scoreboard fed at start time and drained by a monitor process.
module tb_frame_reader;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NPIX = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic          pix_last;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  frame_reader #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .FRAME_PIXELS (NPIX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .dbg_state (dbg_state)
  );

  // data_mem model: one-cycle registered read.
  logic [DW-1:0] mem [NPIX];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // ---------------- scoreboard state ----------------
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  int n_done   = 0;
  int outst    = 0;
  logic        stall_prev = 1'b0;
  logic [DW:0] stall_val  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {pix_valid, pix_last, pix_data}, {1'b1, stall_val});
      if (rd_en) begin
        chk("read_expected", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) chk("rd_addr", rd_addr, exp_addr_q.pop_front());
        outst++;
      end
      if (pix_valid && pix_ready) begin
        chk("pixel_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pix_data", pix_data, e[DW-1:0]);
          chk("pix_last", pix_last, e[DW]);
        end
        hs_cnt++;
        outst--;
      end
      if (rd_en) chk("outstanding_le2", outst <= 2, 1);
      if (done) begin
        n_done++;
        chk("busy_low_with_done", busy, 0);
      end
      stall_prev = pix_valid && !pix_ready;
      stall_val  = {pix_last, pix_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: frame of NPIX words from base, address modulo 2**AW.
  task automatic launch(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    base_addr = base;
    start     = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      a = AW'((int'(base) + i) % NPIX);
      exp_addr_q.push_back(a);
      exp_q.push_back({(i == NPIX - 1), mem[a]});
    end
    step();
    start = 1'b0;
  endtask

  // mode 0: always ready; 1: stall 5 after 2nd pixel then alternate; 2: random.
  task automatic run_until_done(input int mode);
    int k  = 0;
    int bp = 0;
    int h0 = hs_cnt;
    while (!done && k < 300) begin
      case (mode)
        0: pix_ready = 1'b1;
        1: begin
          if (hs_cnt - h0 < 2) pix_ready = 1'b1;
          else if (bp < 5) begin pix_ready = 1'b0; bp++; end
          else pix_ready = ~pix_ready;
        end
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      k++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic preload_ramp();
    for (int i = 0; i < NPIX; i++) mem[i] = DW'(i + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int h0;
    int k;
    preload_ramp();

    // Reset with random inputs: everything reads 0.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start     = 1'($urandom_range(0, 1));
      base_addr = AW'($urandom);
      pix_ready = 1'($urandom_range(0, 1));
      #3;
      chk("reset_outputs", {busy, done, rd_en, pix_valid, pix_last, rd_addr, pix_data}, 0);
      #7;
    end
    start = 1'b0;
    pix_ready = 1'b1;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_after_reset", {rd_en, busy, pix_valid, done}, 0);
    end

    // Full rate with latency and done timing.
    launch(3'd0);
    chk("rd_en_after_start", rd_en, 1);
    chk("busy_after_start", busy, 1);
    chk("pix_valid_e0", pix_valid, 0);
    step();
    chk("pix_valid_e1", pix_valid, 0);
    step();
    chk("first_pixel", {pix_valid, pix_data}, {1'b1, 16'h0001});
    for (int i = 1; i < NPIX; i++) begin
      step();
      chk("full_rate_valid", pix_valid, 1);
    end
    chk("last_pixel", {pix_last, pix_data}, {1'b1, 16'h0008});
    step();
    chk("done_after_last", {done, busy}, 2'b10);
    step();
    chk("done_one_cycle", done, 0);

    // Backpressure.
    d0 = n_done;
    launch(3'd0);
    run_until_done(1);
    step();
    chk("bp_one_done", n_done - d0, 1);

    // Address wrap.
    launch(3'd6);
    run_until_done(0);
    step();

    // Start mid-frame is ignored.
    d0 = n_done;
    launch(3'd0);
    step(); step(); step();
    base_addr = 3'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(0);
    step();
    step();
    chk("midframe_start_one_done", n_done - d0, 1);
    chk("midframe_start_queue", exp_q.size(), 0);

    // Start in the done cycle launches a back-to-back frame.
    d0 = n_done;
    launch(3'd0);
    run_until_done(0);
    launch(3'd0);
    chk("b2b_busy", busy, 1);
    run_until_done(0);
    step();
    chk("b2b_two_done", n_done - d0, 2);

    // Mid-frame reset after 3 pixels.
    launch(3'd0);
    h0 = hs_cnt;
    k  = 0;
    while (hs_cnt - h0 < 3 && k < 20) begin step(); k++; end
    chk("three_pixels_seen", hs_cnt - h0 >= 3, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, rd_en, pix_valid, pix_last, rd_addr, pix_data}, 0);
    exp_q.delete();
    exp_addr_q.delete();
    outst = 0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("post_reset_idle", {busy, pix_valid, rd_en}, 0);
    launch(3'd0);
    run_until_done(0);
    step();

    // Randomized frames: random contents, base and backpressure.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom);
      launch(AW'($urandom_range(0, NPIX - 1)));
      run_until_done(2);
      step();
    end

    chk("queues_drained", exp_q.size() + exp_addr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
